// File: rtl/sram_stream_master.sv
// Request/response adapter for a single tc_sram port: forwards requests in the accept cycle,
// tracks the fixed read latency and buffers returned read data in a credit-protected FIFO.
module sram_stream_master #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RspDepth  = 2,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i,
    output logic                 busy_o
);

    localparam int unsigned CntWidth = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(RspDepth);
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
    localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(RspDepth - 1);
    localparam logic [PtrWidth-1:0] PtrOne  = PtrWidth'(1);

    logic                 init_q;
    logic [CntWidth-1:0]  outstanding_q;
    logic [Latency-1:0]   rd_pipe_q;
    logic [DataWidth-1:0] fifo_mem_q [RspDepth];
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [CntWidth-1:0]  fifo_cnt_q;
    logic                 rd_accept;
    logic                 rsp_hs;
    logic                 push;

    // Credits come only from the registered count, so there is no path from rsp_ready_i.
    assign req_ready_o  = init_q & (req_we_i | (outstanding_q < CntMax));
    assign sram_req_o   = req_valid_i & req_ready_o;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;

    assign rd_accept   = sram_req_o & ~req_we_i;
    assign rsp_valid_o = (fifo_cnt_q != '0);
    assign rsp_rdata_o = fifo_mem_q[rd_ptr_q];
    assign rsp_hs      = rsp_valid_o & rsp_ready_i;
    assign push        = rd_pipe_q[Latency-1];
    assign busy_o      = (outstanding_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q        <= 1'b0;
            outstanding_q <= '0;
            rd_pipe_q     <= '0;
        end else begin
            init_q    <= 1'b1;
            rd_pipe_q <= (rd_pipe_q << 1) | Latency'(rd_accept);
            case ({rd_accept, rsp_hs})
                2'b10:   outstanding_q <= outstanding_q + CntOne;
                2'b01:   outstanding_q <= outstanding_q - CntOne;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Response FIFO; overflow is impossible because every queued or in-flight read holds a credit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(RspDepth); i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= sram_rdata_i;
                wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
            end
            if (rsp_hs) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
            end
            case ({push, rsp_hs})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntOne;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntOne;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_master.sv
// Self-checking bench: table-driven cycle vectors on a Latency=1/RspDepth=2 instance and
// hand-written sequences (deep pipeline, mid-operation reset) on a Latency=3/RspDepth=4 instance.
module tb_sram_stream_master;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 10;
    localparam int unsigned BW = 16;

    typedef struct {
        logic          valid;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic          rsp_ready;
        logic          exp_ready;
        logic          exp_sram_req;
        logic          exp_rsp_valid;
        logic [DW-1:0] exp_rdata;
        logic          exp_busy;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 1: Latency 1, RspDepth 2
    logic          rst1_n, req_valid1, req_ready1, req_we1, rsp_valid1, rsp_ready1;
    logic          sram_req1, sram_we1, busy1;
    logic [AW-1:0] req_addr1, sram_addr1;
    logic [DW-1:0] req_wdata1, rsp_rdata1, sram_wdata1, sram_rdata1;
    logic [BW-1:0] req_be1, sram_be1;

    // Instance 2: Latency 3, RspDepth 4
    logic          rst2_n, req_valid2, req_ready2, req_we2, rsp_valid2, rsp_ready2;
    logic          sram_req2, sram_we2, busy2;
    logic [AW-1:0] req_addr2, sram_addr2;
    logic [DW-1:0] req_wdata2, rsp_rdata2, sram_wdata2, sram_rdata2;
    logic [BW-1:0] req_be2, sram_be2;

    sram_stream_master #(.NumWords(1024), .DataWidth(DW), .ByteWidth(8),
                         .Latency(1), .RspDepth(2)) dut1 (
        .clk_i(clk), .rst_ni(rst1_n),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_we_i(req_we1),
        .req_addr_i(req_addr1), .req_wdata_i(req_wdata1), .req_be_i(req_be1),
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1), .rsp_rdata_o(rsp_rdata1),
        .sram_req_o(sram_req1), .sram_we_o(sram_we1), .sram_addr_o(sram_addr1),
        .sram_wdata_o(sram_wdata1), .sram_be_o(sram_be1), .sram_rdata_i(sram_rdata1),
        .busy_o(busy1)
    );

    sram_stream_master #(.NumWords(1024), .DataWidth(DW), .ByteWidth(8),
                         .Latency(3), .RspDepth(4)) dut2 (
        .clk_i(clk), .rst_ni(rst2_n),
        .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_we_i(req_we2),
        .req_addr_i(req_addr2), .req_wdata_i(req_wdata2), .req_be_i(req_be2),
        .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_rdata_o(rsp_rdata2),
        .sram_req_o(sram_req2), .sram_we_o(sram_we2), .sram_addr_o(sram_addr2),
        .sram_wdata_o(sram_wdata2), .sram_be_o(sram_be2), .sram_rdata_i(sram_rdata2),
        .busy_o(busy2)
    );

    // Behavioural SRAMs; neither is reset, so stale read data keeps flowing through a DUT reset.
    logic [DW-1:0] mem1 [1024];
    logic [DW-1:0] mem2 [1024];
    logic [DW-1:0] pipe2 [3];

    always @(posedge clk) begin
        if (sram_req1 && sram_we1) begin
            for (int b = 0; b < int'(BW); b++)
                if (sram_be1[b]) mem1[sram_addr1][b*8 +: 8] <= sram_wdata1[b*8 +: 8];
        end
        sram_rdata1 <= (sram_req1 && !sram_we1) ? mem1[sram_addr1] : '0;
    end

    always @(posedge clk) begin
        if (sram_req2 && sram_we2) begin
            for (int b = 0; b < int'(BW); b++)
                if (sram_be2[b]) mem2[sram_addr2][b*8 +: 8] <= sram_wdata2[b*8 +: 8];
        end
        pipe2[0] <= (sram_req2 && !sram_we2) ? mem2[sram_addr2] : '0;
        pipe2[1] <= pipe2[0];
        pipe2[2] <= pipe2[1];
    end
    assign sram_rdata2 = pipe2[2];

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        req_valid1 = v.valid;
        req_we1    = v.we;
        req_addr1  = v.addr;
        req_wdata1 = v.wdata;
        req_be1    = v.be;
        rsp_ready1 = v.rsp_ready;
        #1;
    endtask

    function automatic vec_t mk(logic valid, logic we, logic [AW-1:0] addr, logic [DW-1:0] wdata,
                                logic [BW-1:0] be, logic rsp_ready, logic e_ready, logic e_req,
                                logic e_valid, logic [DW-1:0] e_rdata, logic e_busy);
        vec_t v;
        v.valid = valid; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.rsp_ready = rsp_ready; v.exp_ready = e_ready; v.exp_sram_req = e_req;
        v.exp_rsp_valid = e_valid; v.exp_rdata = e_rdata; v.exp_busy = e_busy;
        return v;
    endfunction

    task automatic drive2(input logic valid, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic rsp_ready);
        req_valid2 = valid; req_we2 = we; req_addr2 = addr;
        req_wdata2 = wdata; req_be2 = '1; rsp_ready2 = rsp_ready;
    endtask

    vec_t vecs[$];

    initial begin
        logic [BW-1:0] f;
        f = '1;

        // columns: valid we addr wdata be rsp_ready | ready sram_req rsp_valid rdata busy
        vecs.push_back(mk(1, 1, 'h10, 'hA5A5, f, 1,  1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 'h10, 0, 0, 1,       1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,          1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,          1, 0, 1, 'hA5A5, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,          1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'h20, 'h1111, f, 1,  1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'h21, 'h2222, f, 1,  1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'h22, 'h3333, f, 1,  1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 'h20, 0, 0, 0,       1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 'h21, 0, 0, 0,       1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 'h22, 0, 0, 0,       0, 0, 1, 'h1111, 1));
        vecs.push_back(mk(1, 0, 'h22, 0, 0, 0,       0, 0, 1, 'h1111, 1));
        vecs.push_back(mk(1, 1, 'h30, 'h4444, f, 0,  1, 1, 1, 'h1111, 1));
        vecs.push_back(mk(1, 0, 'h22, 0, 0, 1,       0, 0, 1, 'h1111, 1));
        vecs.push_back(mk(1, 0, 'h22, 0, 0, 1,       1, 1, 1, 'h2222, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,          1, 0, 1, 'h3333, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,          1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'h40, 'h0, f, 1,     1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'h40, 'hABCD, 'h1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 'h40, 0, 0, 1,       1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 'h30, 0, 0, 1,       1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,          0, 0, 1, 'hCD, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,          1, 0, 1, 'h4444, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,          1, 0, 0, 0, 0));

        rst1_n = 1'b0; rst2_n = 1'b0;
        req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0;
        rsp_ready1 = 1'b1;
        drive2(1'b1, 1'b0, '0, '0, 1'b1);

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset req_ready", DW'(req_ready1), DW'(1'b0));
        checkOutput("reset sram_req", DW'(sram_req1), DW'(1'b0));
        checkOutput("reset rsp_valid", DW'(rsp_valid1), DW'(1'b0));
        checkOutput("reset rsp_rdata", rsp_rdata1, '0);
        checkOutput("reset busy", DW'(busy1), DW'(1'b0));
        checkOutput("reset req_ready2", DW'(req_ready2), DW'(1'b0));

        @(negedge clk);
        rst1_n = 1'b1; rst2_n = 1'b1;
        #1;
        checkOutput("init req_ready", DW'(req_ready1), DW'(1'b0));
        checkOutput("init sram_req", DW'(sram_req1), DW'(1'b0));
        req_valid1 = 1'b0;
        req_valid2 = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d req_ready", i), DW'(req_ready1), DW'(vecs[i].exp_ready));
            checkOutput($sformatf("v%0d sram_req", i), DW'(sram_req1), DW'(vecs[i].exp_sram_req));
            checkOutput($sformatf("v%0d rsp_valid", i), DW'(rsp_valid1), DW'(vecs[i].exp_rsp_valid));
            checkOutput($sformatf("v%0d busy", i), DW'(busy1), DW'(vecs[i].exp_busy));
            if (vecs[i].exp_sram_req) begin
                checkOutput($sformatf("v%0d sram_we", i), DW'(sram_we1), DW'(vecs[i].we));
                checkOutput($sformatf("v%0d sram_addr", i), DW'(sram_addr1), DW'(vecs[i].addr));
            end
            if (vecs[i].exp_rsp_valid)
                checkOutput($sformatf("v%0d rsp_rdata", i), rsp_rdata1, vecs[i].exp_rdata);
        end
        @(negedge clk);
        req_valid1 = 1'b0;

        // Deep pipeline: four back-to-back reads return on four consecutive cycles from t+4.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive2(1'b1, 1'b1, AW'(i + 1), DW'(32'h101 + i), 1'b1);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 4) drive2(1'b1, 1'b0, AW'(c + 1), '0, 1'b1);
            else       drive2(1'b0, 1'b0, '0, '0, 1'b1);
            #1;
            checkOutput($sformatf("L3 c%0d sram_req", c), DW'(sram_req2), DW'(c < 4));
            checkOutput($sformatf("L3 c%0d rsp_valid", c), DW'(rsp_valid2), DW'(c >= 4 && c < 8));
            if (c >= 4 && c < 8)
                checkOutput($sformatf("L3 c%0d rsp_rdata", c), rsp_rdata2, DW'(32'h101 + c - 4));
        end

        // Mid-operation reset with two reads in flight; stale SRAM data must be ignored.
        @(negedge clk); drive2(1'b1, 1'b0, AW'(1), '0, 1'b0);
        @(negedge clk); drive2(1'b1, 1'b0, AW'(2), '0, 1'b0);
        @(negedge clk); drive2(1'b1, 1'b0, AW'(3), '0, 1'b0);
        #1;
        checkOutput("pre-rst busy2", DW'(busy2), DW'(1'b1));
        #2 rst2_n = 1'b0;
        #1;
        checkOutput("async rst req_ready2", DW'(req_ready2), DW'(1'b0));
        checkOutput("async rst sram_req2", DW'(sram_req2), DW'(1'b0));
        checkOutput("async rst rsp_valid2", DW'(rsp_valid2), DW'(1'b0));
        checkOutput("async rst busy2", DW'(busy2), DW'(1'b0));
        checkOutput("async rst rsp_rdata2", rsp_rdata2, '0);
        @(negedge clk);
        drive2(1'b0, 1'b0, '0, '0, 1'b1);
        rst2_n = 1'b1;
        #1;
        checkOutput("post-rst req_ready2", DW'(req_ready2), DW'(1'b0));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("stale c%0d rsp_valid2", c), DW'(rsp_valid2), DW'(1'b0));
            checkOutput($sformatf("stale c%0d busy2", c), DW'(busy2), DW'(1'b0));
        end
        checkOutput("recovered req_ready2", DW'(req_ready2), DW'(1'b1));

        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) drive2(1'b1, 1'b0, AW'(4), '0, 1'b1);
            else        drive2(1'b0, 1'b0, '0, '0, 1'b1);
            #1;
            checkOutput($sformatf("after rst c%0d rsp_valid2", c), DW'(rsp_valid2), DW'(c == 4));
            if (c == 4) checkOutput("after rst rsp_rdata2", rsp_rdata2, DW'(32'h104));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_stream_master.md
# sram_stream_master

Initiator-side adapter that drives the single-port request/response interface of the common `tc_sram` macro wrapper. It accepts a valid/ready request stream (read or write), issues each request to the SRAM in the accepting cycle, and tracks the SRAM's fixed read latency. Returned read data goes into a response FIFO, and credit accounting ensures read data is never dropped. It sits between cache/controller logic and one SRAM port.

## Interface
- `NumWords`, 1024, number of SRAM words
- `DataWidth`, 128, data width in bits
- `ByteWidth`, 8, bits per byte-enable lane
- `Latency`, 1, SRAM read latency in cycles; must be ≥1; must match the instantiated SRAM
- `RspDepth`, 2, response FIFO depth and maximum outstanding reads; must be ≥1
- `AddrWidth`, derived, `$clog2(NumWords)` (1 if `NumWords` ≤ 1); do not override
- `BeWidth`, derived, ceil(`DataWidth`/`ByteWidth`); do not override
- Reset: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `req_valid_i`  in  1  request valid
- `req_ready_o`  out  1  request accepted when valid & ready
- `req_we_i`  in  1  1 = write, 0 = read
- `req_addr_i`  in  AddrWidth  word address
- `req_wdata_i`  in  DataWidth  write data
- `req_be_i`  in  BeWidth  write byte enables
- `rsp_valid_o`  out  1  read response valid
- `rsp_ready_i`  in  1  response consumer ready
- `rsp_rdata_o`  out  DataWidth  read data
- `sram_req_o`  out  1  SRAM request
- `sram_we_o`  out  1  SRAM write enable
- `sram_addr_o`  out  AddrWidth  SRAM address
- `sram_wdata_o`  out  DataWidth  SRAM write data
- `sram_be_o`  out  BeWidth  SRAM byte enables
- `sram_rdata_i`  in  DataWidth  SRAM read data
- `busy_o`  out  1  reads in flight or FIFO non-empty

## Operation
- `init_q` flop: cleared by reset, set on the first clock edge after reset release. While `init_q` = 0, `req_ready_o` = 0 and `sram_req_o` = 0.
- `outstanding` counter, range 0..`RspDepth`, registered:
  - +1 on read acceptance; −1 on response handshake (`rsp_valid_o & rsp_ready_i`).
  - Both in the same cycle: no change.
- Ready rule:
  - `req_ready_o = init_q & (req_we_i | (outstanding < RspDepth))`.
  - Uses only the registered count; there is no combinational path from `rsp_ready_i`.
  - Writes are never blocked by credits.
- Accept: `sram_req_o = req_valid_i & req_ready_o`. `sram_we_o`, `sram_addr_o`, `sram_wdata_o` and `sram_be_o` are combinational pass-throughs of the request fields; they are don't-care when `sram_req_o` = 0.
- Read tracking: a `Latency`-stage valid shift register. Stage 0 loads `sram_req_o & ~sram_we_o`. When the last stage is 1, `sram_rdata_i` is pushed into the FIFO on that edge.
- FIFO:
  - In-order, `RspDepth` entries, registered output, no bypass.
  - Cannot overflow, by credit invariant: in-flight reads + FIFO count = `outstanding` ≤ `RspDepth`.
  - A push and a pop in the same cycle are both performed.
- Writes produce no response and complete in the accept cycle.
- `busy_o = (outstanding != 0)`.
- Reset (including mid-operation): in-flight reads discarded, FIFO emptied, `outstanding` = 0. Data returning after reset release from pre-reset reads is ignored.

## Timing
- Reset values:
  - `req_ready_o` = 0, `sram_req_o` = 0, `rsp_valid_o` = 0, `busy_o` = 0.
  - `rsp_rdata_o` = 0 and the other `sram_*` outputs are don't-care while `sram_req_o` = 0.
- Read accepted in cycle t:
  - SRAM data sampled at the end of cycle t+`Latency`.
  - `rsp_valid_o` = 1 from cycle t+`Latency`+1.
  - Total read latency is `Latency`+1 cycles.
- `rsp_valid_o`/`rsp_rdata_o` are held stable until the handshake.
- Throughput: one request per cycle. Reads sustain one per cycle only while `outstanding` < `RspDepth`.
- `req_ready_o` recovers in the cycle after the response handshake that frees a credit.

## Test plan
- Latency=1, RspDepth=2: write addr 0x10 data 0xA5A5, be all-ones; then read 0x10 accepted in cycle t -> `rsp_valid_o` in cycle t+2 with 0xA5A5; `busy_o` high in t+1 and t+2, low in t+3.
- Hold `rsp_ready_i` = 0 and issue 3 back-to-back reads -> first 2 accepted, `req_ready_o` = 0 for the third. Raise `rsp_ready_i` -> responses return in order; third read accepted the cycle after the first pop.
- With credits exhausted (`outstanding` = 2), present a write -> accepted immediately, `sram_req_o` = 1 with `sram_we_o` = 1; `outstanding` stays 2.
- At `outstanding` = RspDepth with a response pending and `rsp_ready_i` = 1 -> `req_ready_o` remains 0 that cycle, read accepted the next cycle; count never exceeds 2.
- Latency=3: 4 back-to-back reads with RspDepth=4 and `rsp_ready_i` = 1 -> responses on 4 consecutive cycles starting t+4, in order.
- Assert `rst_ni` low with 2 reads in flight -> all outputs at reset values asynchronously. After release, late SRAM data is not pushed; `rsp_valid_o` stays 0; first accept is no earlier than one cycle after release.
